fft_r4_bfly_stage: RTL and testbench

Pipelined radix-4 butterfly with twiddle multiplication for the 16-point streaming FFT. It sits directly downstream of the four-lane data_fifo_blk reorder buffer and consumes its four 32-bit lanes plus the block-start control pulse. Each cycle it computes one 4-point DFT column, multiplies output k by W16^(n·k), and forwards results and a delayed control pulse to the next reorder stage.

---
 rtl/fft_r4_bfly_stage.sv | 204 ++++++++++++++++++++
 tb/tb_fft_r4_bfly_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r4_bfly_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_r4_bfly_stage : pipelined radix-4 butterfly with twiddle multiply     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fft_r4_bfly_stage #(
  parameter int SCALE      = 2,
  parameter int TWIDDLE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in_0,
  input  logic [31:0] data_in_1,
  input  logic [31:0] data_in_2,
  input  logic [31:0] data_in_3,
  input  logic        ctrl_in,
  output logic [31:0] data_out_0,
  output logic [31:0] data_out_1,
  output logic [31:0] data_out_2,
  output logic [31:0] data_out_3,
  output logic        ctrl_out
);

  localparam logic signed [33:0] c_RND1 = 34'((2 ** SCALE) / 2);

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767)       return 16'sh7fff;
    else if (v < -34'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] scale_sat(input logic signed [17:0] v);
    logic signed [33:0] t;
    t = 34'(v) + c_RND1;
    t = t >>> SCALE;
    return sat16(t);
  endfunction

  // Q2.14 {wr, wi} with wi = -sin; only m in {0,1,2,3,4,6,9} can occur
  function automatic logic [31:0] twiddle(input logic [3:0] m);
    case (m)
      4'd0:    return {16'sd16384,  16'sd0};
      4'd1:    return {16'sd15137, -16'sd6270};
      4'd2:    return {16'sd11585, -16'sd11585};
      4'd3:    return {16'sd6270,  -16'sd15137};
      4'd4:    return {16'sd0,     -16'sd16384};
      4'd6:    return {-16'sd11585, -16'sd11585};
      4'd9:    return {-16'sd15137, 16'sd6270};
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0]        w_in [4];
  logic [31:0]        in_q [4];
  logic [1:0]         n_q, n_d;
  logic               ctrl0_q, ctrl1_q, ctrl2_q, ctrl3_q;
  logic signed [17:0] w_ar [4], w_ai [4], w_xr [4], w_xi [4];
  logic signed [15:0] s1_re_d [4], s1_im_d [4], s1_re_q [4], s1_im_q [4];
  logic signed [15:0] out_re_d [4], out_im_d [4], out_re_q [4], out_im_q [4];

  assign w_in[0] = data_in_0;
  assign w_in[1] = data_in_1;
  assign w_in[2] = data_in_2;
  assign w_in[3] = data_in_3;

  assign n_d = ctrl_in ? 2'd0 : n_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) in_q[j] <= '0;
      n_q     <= '0;
      ctrl0_q <= 1'b0;
      ctrl1_q <= 1'b0;
      ctrl2_q <= 1'b0;
      ctrl3_q <= 1'b0;
    end else begin
      for (int j = 0; j < 4; j++) in_q[j] <= w_in[j];
      n_q     <= n_d;
      ctrl0_q <= ctrl_in;
      ctrl1_q <= ctrl0_q;
      ctrl2_q <= ctrl1_q;
      ctrl3_q <= ctrl2_q;
    end
  end

  // -j*(r + j*i) = i - j*r folds the j-rotations into plain add/sub
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_ar[j] = 18'($signed(in_q[j][31:16]));
      w_ai[j] = 18'($signed(in_q[j][15:0]));
    end
    w_xr[0] = w_ar[0] + w_ar[1] + w_ar[2] + w_ar[3];
    w_xi[0] = w_ai[0] + w_ai[1] + w_ai[2] + w_ai[3];
    w_xr[1] = w_ar[0] + w_ai[1] - w_ar[2] - w_ai[3];
    w_xi[1] = w_ai[0] - w_ar[1] - w_ai[2] + w_ar[3];
    w_xr[2] = w_ar[0] - w_ar[1] + w_ar[2] - w_ar[3];
    w_xi[2] = w_ai[0] - w_ai[1] + w_ai[2] - w_ai[3];
    w_xr[3] = w_ar[0] - w_ai[1] - w_ar[2] + w_ai[3];
    w_xi[3] = w_ai[0] + w_ar[1] - w_ai[2] - w_ar[3];
    for (int k = 0; k < 4; k++) begin
      s1_re_d[k] = scale_sat(w_xr[k]);
      s1_im_d[k] = scale_sat(w_xi[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        s1_re_q[k] <= '0;
        s1_im_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        s1_re_q[k] <= s1_re_d[k];
        s1_im_q[k] <= s1_im_d[k];
      end
    end
  end

  if (TWIDDLE_EN != 0) begin : g_tw
    logic [1:0]         n1_q;
    logic signed [15:0] w_wr [4], w_wi [4];
    logic signed [31:0] p_rr_q [4], p_ii_q [4], p_ri_q [4], p_ir_q [4];

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        {w_wr[k], w_wi[k]} = twiddle(4'(n1_q) * 4'(k));
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        n1_q <= '0;
        for (int k = 0; k < 4; k++) begin
          p_rr_q[k] <= '0;
          p_ii_q[k] <= '0;
          p_ri_q[k] <= '0;
          p_ir_q[k] <= '0;
        end
      end else begin
        n1_q <= n_q;
        for (int k = 0; k < 4; k++) begin
          p_rr_q[k] <= 32'(s1_re_q[k]) * 32'(w_wr[k]);
          p_ii_q[k] <= 32'(s1_im_q[k]) * 32'(w_wi[k]);
          p_ri_q[k] <= 32'(s1_re_q[k]) * 32'(w_wi[k]);
          p_ir_q[k] <= 32'(s1_im_q[k]) * 32'(w_wr[k]);
        end
      end
    end

    // W^0 = 16384 makes (x*2^14 + 2^13) >>> 14 == x, so lane 0 stays exact
    always_comb begin
      for (int k = 0; k < 4; k++) begin
        out_re_d[k] = sat16((34'(p_rr_q[k]) - 34'(p_ii_q[k]) + 34'sd8192) >>> 14);
        out_im_d[k] = sat16((34'(p_ri_q[k]) + 34'(p_ir_q[k]) + 34'sd8192) >>> 14);
      end
    end
  end else begin : g_byp
    logic signed [15:0] b_re_q [4], b_im_q [4];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          b_re_q[k] <= '0;
          b_im_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          b_re_q[k] <= s1_re_q[k];
          b_im_q[k] <= s1_im_q[k];
        end
      end
    end

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        out_re_d[k] = b_re_q[k];
        out_im_d[k] = b_im_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        out_re_q[k] <= out_re_d[k];
        out_im_q[k] <= out_im_d[k];
      end
    end
  end

  assign data_out_0 = {out_re_q[0], out_im_q[0]};
  assign data_out_1 = {out_re_q[1], out_im_q[1]};
  assign data_out_2 = {out_re_q[2], out_im_q[2]};
  assign data_out_3 = {out_re_q[3], out_im_q[3]};
  assign ctrl_out   = ctrl3_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_r4_bfly_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_r4_bfly_stage : directed + random checks of three configurations   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fft_r4_bfly_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             ctrl_in;
  logic [3:0][31:0] din;
  logic [3:0][31:0] dout [3];
  logic [2:0]       cout;

  // cfg 0: SCALE=0 twiddled, cfg 1: SCALE=2 twiddled, cfg 2: SCALE=0 bypass
  fft_r4_bfly_stage #(.SCALE(0), .TWIDDLE_EN(1)) u_s0 (
    .clk(clk), .rst(rst),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .ctrl_in(ctrl_in),
    .data_out_0(dout[0][0]), .data_out_1(dout[0][1]), .data_out_2(dout[0][2]), .data_out_3(dout[0][3]),
    .ctrl_out(cout[0])
  );
  fft_r4_bfly_stage #(.SCALE(2), .TWIDDLE_EN(1)) u_s2 (
    .clk(clk), .rst(rst),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .ctrl_in(ctrl_in),
    .data_out_0(dout[1][0]), .data_out_1(dout[1][1]), .data_out_2(dout[1][2]), .data_out_3(dout[1][3]),
    .ctrl_out(cout[1])
  );
  fft_r4_bfly_stage #(.SCALE(0), .TWIDDLE_EN(0)) u_byp (
    .clk(clk), .rst(rst),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .ctrl_in(ctrl_in),
    .data_out_0(dout[2][0]), .data_out_1(dout[2][1]), .data_out_2(dout[2][2]), .data_out_3(dout[2][3]),
    .ctrl_out(cout[2])
  );

  typedef struct packed {
    logic [2:0][3:0][31:0] d;
    logic                  c;
  } rec_t;

  rec_t q[$];
  int   n_chk;
  int   n_fail;
  int   n_m;
  int   step_no;
  int   twr [10] = '{16384, 15137, 11585, 6270, 0, 0, -11585, 0, 0, -15137};
  int   twi [10] = '{0, -6270, -11585, -15137, -16384, 0, -11585, 0, 0, 6270};

  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // X_k = sum_j a_j * (-j)^(j*k), scaled, then times W16^(n*k)
  function automatic logic [3:0][31:0] model(input logic [3:0][31:0] a, input int n,
                                              input int sc, input bit tw);
    logic [3:0][31:0] res;
    for (int k = 0; k < 4; k++) begin
      longint xr, xi, sr, si, yr, yi, rnd;
      int m;
      xr = 0;
      xi = 0;
      for (int j = 0; j < 4; j++) begin
        longint r, i, t;
        r = longint'($signed(a[j][31:16]));
        i = longint'($signed(a[j][15:0]));
        for (int p = 0; p < (j * k) % 4; p++) begin
          t = r;
          r = i;
          i = -t;
        end
        xr += r;
        xi += i;
      end
      rnd = (sc > 0) ? (longint'(1) << (sc - 1)) : 0;
      sr  = sat((xr + rnd) >>> sc);
      si  = sat((xi + rnd) >>> sc);
      if (tw) begin
        m  = n * k;
        yr = sat((sr * twr[m] - si * twi[m] + 8192) >>> 14);
        yi = sat((sr * twi[m] + si * twr[m] + 8192) >>> 14);
      end else begin
        yr = sr;
        yi = si;
      end
      res[k] = {16'(yr), 16'(yi)};
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0][31:0] d, input logic c, input logic r);
    rec_t rec, e;
    din     = d;
    ctrl_in = c;
    rst     = r;
    @(posedge clk);
    if (!r) begin
      q.delete();
      repeat (3) q.push_back('0);
      n_m = 0;
      rec = '0;
    end else begin
      n_m = c ? 0 : (n_m + 1) % 4;
      for (int g = 0; g < 3; g++) rec.d[g] = model(d, n_m, (g == 1) ? 2 : 0, g != 2);
      rec.c = c;
    end
    q.push_back(rec);
    e = q.pop_front();
    #1;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("s%0d_cfg%0d_out%0d", step_no, g, k), dout[g][k], e.d[g][k]);
      chk($sformatf("s%0d_cfg%0d_ctrl", step_no, g), {31'b0, cout[g]}, {31'b0, e.c});
    end
    step_no++;
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [3:0][31:0] imp;
    logic [31:0]      sw [4][4];
    n_chk   = 0;
    n_fail  = 0;
    n_m     = 0;
    step_no = 0;
    rst     = 1'b0;
    ctrl_in = 1'b0;
    din     = '0;
    repeat (3) q.push_back('0);

    repeat (4) step('0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      chk("reset_out0", dout[g][0], 32'd0);
      chk("reset_ctrl", {31'b0, cout[g]}, 32'd0);
    end

    // Impulse, SCALE=0
    imp    = '0;
    imp[0] = cx(1000, 0);
    step(imp, 1'b1, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("impulse_out%0d", k), dout[0][k], cx(1000, 0));
    chk("impulse_ctrl", {31'b0, cout[0]}, 32'd1);

    // DC, SCALE=2
    d = {4{cx(1000, 0)}};
    step(d, 1'b1, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    chk("dc_out0", dout[1][0], cx(1000, 0));
    for (int k = 1; k < 4; k++) chk($sformatf("dc_out%0d", k), dout[1][k], 32'd0);

    // Twiddle sweep, SCALE=0
    sw[0] = '{cx(16384, 0), cx(16384, 0), cx(16384, 0), cx(16384, 0)};
    sw[1] = '{cx(16384, 0), cx(15137, -6270), cx(11585, -11585), cx(6270, -15137)};
    sw[2] = '{cx(16384, 0), cx(11585, -11585), cx(0, -16384), cx(-11585, -11585)};
    sw[3] = '{cx(16384, 0), cx(6270, -15137), cx(-11585, -11585), cx(-15137, 6270)};
    for (int c = 0; c < 7; c++) begin
      d = '0;
      if (c < 4) d[0] = cx(16384, 0);
      step(d, c == 0, 1'b1);
      if (c >= 3) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("sweep_col%0d_out%0d", c - 3, k), dout[0][k], sw[c - 3][k]);
        chk($sformatf("sweep_col%0d_ctrl", c - 3), {31'b0, cout[0]}, 32'(c == 3));
      end
    end

    // Saturation, SCALE=0
    d = {4{cx(32767, -32768)}};
    step(d, 1'b1, 1'b1);
    repeat (3) step('0, 1'b0, 1'b1);
    chk("sat_out0", dout[0][0], cx(32767, -32768));
    chk("sat_out2", dout[0][2], 32'd0);

    // Mid-block ctrl restarts n at 0
    imp[0] = cx(16384, 0);
    step(imp, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    step(imp, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("restart_ctrl_a", {31'b0, cout[0]}, 32'd1);
    step('0, 1'b0, 1'b1);
    chk("restart_ctrl_gap", {31'b0, cout[0]}, 32'd0);
    step('0, 1'b0, 1'b1);
    chk("restart_ctrl_b", {31'b0, cout[0]}, 32'd1);
    chk("restart_n0_out1", dout[0][1], cx(16384, 0));

    // Reset one cycle after ctrl_in drops the in-flight pulse
    step(imp, 1'b1, 1'b1);
    step('0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) chk($sformatf("rst_cfg%0d_out%0d", g, k), dout[g][k], 32'd0);
    repeat (5) begin
      step('0, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) chk($sformatf("rst_noctrl_cfg%0d", g), {31'b0, cout[g]}, 32'd0);
    end

    // Bypass, column-1 impulse, latency 3
    step('0, 1'b1, 1'b1);
    step(imp, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("bypass_early_out1", dout[2][1], 32'd0);
    step('0, 1'b0, 1'b1);
    chk("bypass_out1", dout[2][1], cx(16384, 0));

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 4; j++) begin
        d[j] = $urandom;
        if ($urandom_range(0, 7) == 0) d[j] = ($urandom_range(0, 1) != 0) ? cx(-32768, -32768) : cx(32767, 32767);
      end
      step(d, $urandom_range(0, 5) == 0, $urandom_range(0, 60) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
